// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings, response/command record types and small
// helpers used by the command master, its response FIFO and its checker.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    localparam int AHBL_ADDR_W = 32;
    localparam int AHBL_DATA_W = 32;

    typedef struct packed {
        logic [AHBL_ADDR_W-1:0] addr;
        logic                   write;
        logic [2:0]             size;
        logic [AHBL_DATA_W-1:0] wdata;
    } ahbl_cmd_t;

    typedef struct packed {
        logic [AHBL_DATA_W-1:0] rdata;
        logic                   write;
        logic                   error;
    } ahbl_rsp_t;

    // The bus is only 32 bits wide, so anything wider is issued as a word.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        logic [2:0] res;
        if (size > HSIZE_WORD) begin
            res = HSIZE_WORD;
        end else begin
            res = size;
        end
        return res;
    endfunction

    function automatic logic size_aligned(input logic [1:0] addr_lo, input logic [2:0] size);
        logic ok;
        case (clamp_size(size))
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = (addr_lo[0] == 1'b0);
            default:    ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahbl_cmd_master_chk.sv
// Simulation-time property checks for the command master bus behaviour.
module ahbl_cmd_master_chk
    import ahbl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              rst_n,
    input logic              accept,
    input logic [1:0]        cmd_addr_lo,
    input logic [2:0]        cmd_size,
    input logic              hready,
    input logic [1:0]        htrans,
    input logic [ADDR_W-1:0] haddr,
    input logic              hwrite,
    input logic [2:0]        hsize,
    input logic [DATA_W-1:0] hwdata,
    input logic              push,
    input logic              fifo_full
);

    a_cmd_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> size_aligned(cmd_addr_lo, cmd_size));

    a_ctrl_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (htrans == HTRANS_NONSEQ && !hready) |=>
            ($stable(haddr) && $stable(htrans) && $stable(hwrite) && $stable(hsize)));

    a_wdata_stable: assert property (@(posedge clk) disable iff (!rst_n)
        !hready |=> $stable(hwdata));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> !fifo_full);

endmodule

// File: rtl/ahbl_rsp_fifo.sv
// Synchronous response FIFO; simultaneous push and pop are both honoured.
module ahbl_rsp_fifo
    import ahbl_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = ahbl_rsp_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    T               mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW:0]    count_r;
    logic           do_push_s;
    logic           do_pop_s;

    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign count    = count_r;
    assign full     = (count_r == (AW+1)'(DEPTH));
    assign empty    = (count_r == (AW+1)'(0));

endmodule

// File: rtl/ahbl_cmd_master.sv
// Command-driven AHB-Lite initiator: one single transfer per accepted command,
// responses returned in order through a credit-limited FIFO.
module ahbl_cmd_master
    import ahbl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RSP_DEPTH = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_write,
    output logic              rsp_error,
    output logic              busy,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);
    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int OW = CW + 1;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              write;
        logic              error;
    } rsp_t;

    logic              ap_valid_r;
    logic [ADDR_W-1:0] haddr_r;
    logic              hwrite_r;
    logic [2:0]        hsize_r;
    logic [DATA_W-1:0] ap_wdata_r;
    logic              dp_valid_r;
    logic              dp_write_r;
    logic [DATA_W-1:0] hwdata_r;

    logic              accept_s;
    logic              ap_done_s;
    logic              dp_done_s;
    logic              pop_s;
    logic [OW-1:0]     occ_s;
    logic              credit_ok_s;
    logic [CW-1:0]     fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    rsp_t              push_data_s;
    rsp_t              head_s;

    // Every accepted command holds a FIFO slot from accept until it is popped.
    assign occ_s       = OW'(fifo_count_s) + OW'(ap_valid_r) + OW'(dp_valid_r);
    assign pop_s       = rsp_valid & rsp_ready;
    assign credit_ok_s = (occ_s - OW'(pop_s)) < OW'(RSP_DEPTH);
    assign cmd_ready   = HRESETn & (~ap_valid_r | HREADY) & credit_ok_s;
    assign accept_s    = cmd_valid & cmd_ready;
    assign ap_done_s   = ap_valid_r & HREADY;
    assign dp_done_s   = dp_valid_r & HREADY;

    // Address-phase slot; controls keep their last value once the slot empties.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_valid_r <= 1'b0;
            haddr_r    <= '0;
            hwrite_r   <= 1'b0;
            hsize_r    <= HSIZE_WORD;
            ap_wdata_r <= '0;
        end else if (accept_s) begin
            ap_valid_r <= 1'b1;
            haddr_r    <= cmd_addr;
            hwrite_r   <= cmd_write;
            hsize_r    <= clamp_size(cmd_size);
            ap_wdata_r <= cmd_wdata;
        end else if (ap_done_s) begin
            ap_valid_r <= 1'b0;
        end
    end

    // Data-phase slot; HWDATA only changes when a write enters the data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_r <= 1'b0;
            dp_write_r <= 1'b0;
            hwdata_r   <= '0;
        end else if (ap_done_s) begin
            dp_valid_r <= 1'b1;
            dp_write_r <= hwrite_r;
            if (hwrite_r) begin
                hwdata_r <= ap_wdata_r;
            end
        end else if (dp_done_s) begin
            dp_valid_r <= 1'b0;
        end
    end

    assign push_data_s.rdata = dp_write_r ? '0 : HRDATA;
    assign push_data_s.write = dp_write_r;
    assign push_data_s.error = HRESP;

    ahbl_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .T     (rsp_t)
    ) u_rsp_fifo (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .push      (dp_done_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    ahbl_cmd_master_chk #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_chk (
        .clk         (HCLK),
        .rst_n       (HRESETn),
        .accept      (accept_s),
        .cmd_addr_lo (cmd_addr[1:0]),
        .cmd_size    (cmd_size),
        .hready      (HREADY),
        .htrans      (HTRANS),
        .haddr       (HADDR),
        .hwrite      (HWRITE),
        .hsize       (HSIZE),
        .hwdata      (HWDATA),
        .push        (dp_done_s),
        .fifo_full   (fifo_full_s)
    );

    assign rsp_valid = ~fifo_empty_s;
    assign rsp_rdata = head_s.rdata;
    assign rsp_write = head_s.write;
    assign rsp_error = head_s.error;
    assign busy      = ap_valid_r | dp_valid_r | ~fifo_empty_s;

    assign HTRANS    = ap_valid_r ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = haddr_r;
    assign HWRITE    = hwrite_r;
    assign HSIZE     = hsize_r;
    assign HWDATA    = hwdata_r;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DEFAULT;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahbl_cmd_master.sv
// Directed bench for ahbl_cmd_master: a tiny slave model answers reads with
// addr^0xFFFF_FFFF, and a scoreboard checks responses in command order.
module tb_ahbl_cmd_master;

    typedef struct packed {
        logic [31:0] rdata;
        logic        write;
        logic        error;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_write;
    logic        rsp_error;
    logic        busy;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    logic [31:0] s_addr = 32'h0;
    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    ahbl_cmd_master #(.ADDR_W(32), .DATA_W(32), .RSP_DEPTH(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_write(rsp_write), .rsp_error(rsp_error), .busy(busy),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    // Slave model: capture the address phase, return garbage during wait states.
    always @(posedge HCLK) begin
        if (HREADY && HTRANS == 2'b10) begin
            s_addr <= HADDR;
        end
    end
    assign HRDATA = HREADY ? (s_addr ^ 32'hFFFF_FFFF) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Response monitor: the handshake completes at the next rising edge.
    always @(negedge HCLK) begin
        if (HRESETn && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_write", {31'h0, rsp_write}, {31'h0, e.write});
                check("rsp_error", {31'h0, rsp_error}, {31'h0, e.error});
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic send(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [31:0] erdata,
                        input logic eerr, output int waited);
        exp_t e;
        cmd_addr  = addr;
        cmd_write = wr;
        cmd_size  = size;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        waited    = 0;
        #1;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!cmd_ready) begin
            check("send_timeout", 32'h1, 32'h0);
            cmd_valid = 1'b0;
        end else begin
            e.rdata = erdata;
            e.write = wr;
            e.error = eerr;
            sb_q.push_back(e);
            tick();
            cmd_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check({name, "_idle"}, {31'h0, busy}, 32'h0);
        check({name, "_sb_empty"}, sb_q.size(), 32'h0);
    endtask

    task automatic write_latency(input string name);
        int w;
        rsp_ready = 1'b0;
        send(32'h5300_0000, 1'b1, 3'b010, 32'h0000_00A5, 32'h0, 1'b0, w);
        check({name, "_wait"}, w, 32'h0);
        check({name, "_htrans_c1"}, {30'h0, HTRANS}, 32'h2);
        check({name, "_haddr_c1"}, HADDR, 32'h5300_0000);
        check({name, "_hwrite_c1"}, {31'h0, HWRITE}, 32'h1);
        tick();
        check({name, "_hwdata_c2"}, HWDATA, 32'h0000_00A5);
        check({name, "_htrans_c2"}, {30'h0, HTRANS}, 32'h0);
        check({name, "_rsp_valid_c2"}, {31'h0, rsp_valid}, 32'h0);
        tick();
        check({name, "_rsp_valid_c3"}, {31'h0, rsp_valid}, 32'h1);
        rsp_ready = 1'b1;
        tick();
        check({name, "_rsp_valid_after"}, {31'h0, rsp_valid}, 32'h0);
        check({name, "_busy_after"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [31:0] t2_addr [4];
        logic [31:0] t4_addr [6];
        logic [31:0] t4_exp  [6];
        t2_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
        t4_addr = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114};
        t4_exp  = '{32'hFFFF_FEFF, 32'hFFFF_FEFB, 32'h0, 32'hFFFF_FEF3, 32'hFFFF_FEEF, 32'hFFFF_FEEB};

        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_write = 1'b0;
        cmd_size = 3'b010; cmd_wdata = 32'h0; rsp_ready = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (3) tick();
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("rst_htrans", {30'h0, HTRANS}, 32'h0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hsize", {29'h0, HSIZE}, 32'h2);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("tie_hburst", {29'h0, HBURST}, 32'h0);
        check("tie_hprot", {28'h0, HPROT}, 32'h3);
        check("tie_hmastlock", {31'h0, HMASTLOCK}, 32'h0);
        HRESETn = 1'b1;
        tick();

        // Test 1: single write, minimum latency.
        write_latency("t1");

        // Test 2: four back-to-back reads; first uses an oversize HSIZE.
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(t2_addr[i], 1'b0, (i == 0) ? 3'b111 : 3'b010, 32'h0,
                 t2_addr[i] ^ 32'hFFFF_FFFF, 1'b0, w);
            check("t2_no_bubble", w, 32'h0);
            check("t2_htrans", {30'h0, HTRANS}, 32'h2);
            check("t2_haddr", HADDR, t2_addr[i]);
            check("t2_hsize", {29'h0, HSIZE}, 32'h2);
        end
        drain("t2");

        // Test 3: three wait states in a read data phase with next address pending.
        send(32'h10, 1'b0, 3'b010, 32'h0, 32'hFFFF_FFEF, 1'b0, w);
        send(32'h14, 1'b0, 3'b010, 32'h0, 32'hFFFF_FFEB, 1'b0, w);
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_haddr_hold", HADDR, 32'h14);
            check("t3_htrans_hold", {30'h0, HTRANS}, 32'h2);
            check("t3_no_rsp", {31'h0, rsp_valid}, 32'h0);
            tick();
        end
        HREADY = 1'b1;
        drain("t3");

        // Test 4: credits stop acceptance at four outstanding commands.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(t4_addr[i], (i == 2), 3'b010, 32'h1111_0000, t4_exp[i], 1'b0, w);
            check("t4_accept", w, 32'h0);
        end
        cmd_addr = t4_addr[4]; cmd_write = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_blocked", {31'h0, cmd_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        for (int i = 4; i < 6; i++) begin
            send(t4_addr[i], 1'b0, 3'b010, 32'h0, t4_exp[i], 1'b0, w);
        end
        drain("t4");

        // Test 5: two-cycle error response on a write followed by a read.
        send(32'h2000_0000, 1'b1, 3'b010, 32'h0000_1234, 32'h0, 1'b1, w);
        send(32'h2000_0004, 1'b0, 3'b010, 32'h0, 32'hDFFF_FFFB, 1'b0, w);
        HREADY = 1'b0; HRESP = 1'b1;
        tick();
        HREADY = 1'b1;
        check("t5_haddr_kept", HADDR, 32'h2000_0004);
        check("t5_htrans_kept", {30'h0, HTRANS}, 32'h2);
        tick();
        HRESP = 1'b0;
        check("t5_read_in_dp", {30'h0, HTRANS}, 32'h0);
        drain("t5");

        // Test 6: reset during a data-phase wait state.
        send(32'h30, 1'b0, 3'b010, 32'h0, 32'hFFFF_FFCF, 1'b0, w);
        send(32'h34, 1'b0, 3'b010, 32'h0, 32'hFFFF_FFCB, 1'b0, w);
        HREADY = 1'b0;
        tick();
        #2;
        HRESETn = 1'b0;
        #1;
        check("t6_htrans_idle", {30'h0, HTRANS}, 32'h0);
        check("t6_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("t6_busy", {31'h0, busy}, 32'h0);
        check("t6_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        sb_q.delete();
        tick();
        tick();
        HREADY = 1'b1;
        HRESETn = 1'b1;
        tick();
        write_latency("t6");
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
